instr_sequencer: RTL and testbench

- Program-driven instruction source that sits directly upstream of the datapath. It replaces the hard-coded per-state opcode case list with a loadable program memory.
- Holds up to DEPTH 16-bit instruction words and walks a program counter through them, presenting one instruction per issue slot on instr_out.
- Captures the flags the datapath returns and derives the carry-in for the next instruction.
- Supports free-run and single-step modes, plus a halt word. The Fibonacci register-file test becomes a loaded program rather than a bespoke FSM.

---
 rtl/instr_sequencer_if.sv | 31 +++
 rtl/instr_sequencer.sv | 125 ++++++++++++
 tb/tb_instr_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - program load, run control, flag return and instruction issue signals
interface instr_sequencer_if #(
  parameter int AW = 5
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic          start;
  logic          step_mode;
  logic          step;
  logic [4:0]    flags_in;
  logic [15:0]   instr_out;
  logic          instr_valid;
  logic          cin_out;
  logic [AW-1:0] pc;
  logic [2:0]    state;
  logic          halted;
  logic [7:0]    issue_count;

  // Driver side: loads the program, controls execution, returns datapath flags
  modport master (
    output load_en, load_addr, load_data, start, step_mode, step, flags_in,
    input  instr_out, instr_valid, cin_out, pc, state, halted, issue_count
  );

  // Sequencer side
  modport slave (
    input  load_en, load_addr, load_data, start, step_mode, step, flags_in,
    output instr_out, instr_valid, cin_out, pc, state, halted, issue_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - loadable program memory walked by a pc, issuing one instruction per slot
module instr_sequencer #(
  parameter int          DEPTH     = 32,
  parameter int          AW        = 5,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter logic [15:0] NOP_WORD  = 16'h0000,
  parameter int          CARRY_BIT = 3
) (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [4:0]    flag_q, flag_d;
  logic          pend_q, pend_d;
  logic [7:0]    count_q, count_d;

  logic [15:0]   mem [DEPTH];
  logic [15:0]   fetch_word;
  logic          load_ok;

  // The program may only change while nothing is executing
  assign load_ok    = bus.load_en && (state_q == S_IDLE || state_q == S_HALT);
  assign fetch_word = mem[pc_q];

  // Program memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // State, pc, instruction register, flags and issue counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flag_q  <= '0;
      pend_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: fetch/issue walk, step gating, halt detection and flag capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flag_d  = flag_q;
    pend_d  = pend_q;
    count_d = count_q;

    // Datapath flags arrive the cycle after an issue, whatever state follows it
    if (pend_q) begin
      flag_d = bus.flags_in;
      pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        // A start wins over any flag capture still pending from the last run
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          count_d = '0;
          flag_d  = '0;
          pend_d  = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = fetch_word;
        state_d = (fetch_word == HALT_WORD) ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        pend_d = 1'b1;
        if (count_q != 8'hFF) begin
          count_d = count_q + 8'd1;
        end
        // pc naturally wraps to 0 after the last word
        pc_d = pc_q + AW'(1);
        if (pc_q == AW'(DEPTH - 1)) begin
          state_d = S_HALT;
        end else if (bus.step_mode) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (bus.step) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.instr_valid = (state_q == S_ISSUE);
  assign bus.instr_out   = (state_q == S_ISSUE) ? ir_q : NOP_WORD;
  assign bus.cin_out     = flag_q[CARRY_BIT];
  assign bus.pc          = pc_q;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.issue_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_sequencer_if #(.AW(AW)) bus();
  instr_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic        start;
    logic [4:0]  flags;
    logic        valid;
    logic [15:0] instr;
    logic [2:0]  st;
    logic [4:0]  pc;
    logic [7:0]  cnt;
    logic        cin;
    logic        halted;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.step      = 1'b0;
    bus.flags_in  = '0;
  endtask

  task automatic load_word(input int addr, input logic [15:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = AW'(addr);
    bus.load_data = data;
    tick;
    bus.load_en   = 1'b0;
  endtask

  task automatic load_demo;
    load_word(0, 16'h5001);
    load_word(1, 16'h5101);
    load_word(2, 16'h0150);
    load_word(3, 16'hFFFF);
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.halted && n < budget) begin
      tick;
      n++;
    end
    if (!bus.halted) check({name, "_halt_timeout"}, 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          seen;
    logic [15:0] prog [DEPTH];
    logic [15:0] expq [$];

    // cycle-by-cycle expectations for the demo program in free-run
    vt[0] = '{1'b1, 5'b00000, 1'b0, 16'h0000, 3'd1, 5'd0, 8'd0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 5'b00000, 1'b1, 16'h5001, 3'd2, 5'd0, 8'd0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 5'b00000, 1'b0, 16'h0000, 3'd1, 5'd1, 8'd1, 1'b0, 1'b0};
    vt[3] = '{1'b0, 5'b01000, 1'b1, 16'h5101, 3'd2, 5'd1, 8'd1, 1'b1, 1'b0};
    vt[4] = '{1'b0, 5'b00000, 1'b0, 16'h0000, 3'd1, 5'd2, 8'd2, 1'b1, 1'b0};
    vt[5] = '{1'b0, 5'b00000, 1'b1, 16'h0150, 3'd2, 5'd2, 8'd2, 1'b0, 1'b0};
    vt[6] = '{1'b0, 5'b01000, 1'b0, 16'h0000, 3'd1, 5'd3, 8'd3, 1'b0, 1'b0};
    vt[7] = '{1'b0, 5'b00000, 1'b0, 16'h0000, 3'd4, 5'd3, 8'd3, 1'b0, 1'b1};
    vt[8] = '{1'b0, 5'b00000, 1'b0, 16'h0000, 3'd4, 5'd3, 8'd3, 1'b0, 1'b1};

    idle_inputs;
    bus.step_mode = 1'b0;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;

    // reset state
    check("rst_state", bus.state, 0);
    check("rst_pc", bus.pc, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_instr", bus.instr_out, 16'h0000);
    check("rst_count", bus.issue_count, 0);
    check("rst_cin", bus.cin_out, 0);
    check("rst_halted", bus.halted, 0);

    // empty program: memory filled with the halt word
    for (int a = 0; a < DEPTH; a++) load_word(a, 16'hFFFF);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("empty_fetch_state", bus.state, 1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (bus.instr_valid) seen++;
    end
    check("empty_no_issue", seen, 0);
    check("empty_state", bus.state, 4);
    check("empty_count", bus.issue_count, 0);
    check("empty_halted", bus.halted, 1);

    // table-driven free-run of the demo program, started from HALT
    load_demo;
    for (int i = 0; i < 9; i++) begin
      bus.start    = vt[i].start;
      bus.flags_in = vt[i].flags;
      tick;
      check($sformatf("vec%0d", i),
            {bus.instr_valid, bus.instr_out, bus.state, bus.pc, bus.issue_count, bus.cin_out, bus.halted},
            {vt[i].valid, vt[i].instr, vt[i].st, vt[i].pc, vt[i].cnt, vt[i].cin, vt[i].halted});
    end
    idle_inputs;

    // single-step mode
    bus.step_mode = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    check("step_first_instr", bus.instr_out, 16'h5001);
    tick;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.step_mode = 1'b0;
      bus.start = (i == 5);
      check($sformatf("step_hold%0d", i), {bus.state, bus.pc}, {3'd3, 5'd1});
      tick;
    end
    bus.start = 1'b0;
    check("step_hold_end", {bus.state, bus.pc}, {3'd3, 5'd1});
    bus.step_mode = 1'b1;
    bus.step = 1'b1;
    tick;
    bus.step = 1'b0;
    tick;
    check("step_second_instr", {bus.instr_valid, bus.instr_out}, {1'b1, 16'h5101});
    tick;
    check("step_wait2", bus.state, 3);
    bus.step = 1'b1;
    tick;
    check("step_fetch", bus.state, 1);
    tick;
    bus.step = 1'b0;
    check("step_third_instr", bus.instr_out, 16'h0150);
    tick;
    tick;
    tick;
    check("step_in_fetch_ignored", {bus.state, bus.pc}, {3'd3, 5'd3});
    bus.step = 1'b1;
    tick;
    bus.step = 1'b0;
    tick;
    check("step_end_halt", {bus.halted, bus.issue_count}, {1'b1, 8'd3});
    bus.step_mode = 1'b0;

    // full memory of real instructions: pc wraps and the run halts
    for (int a = 0; a < DEPTH; a++) load_word(a, 16'h0150);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !bus.halted; i++) begin
      if (bus.instr_valid) seen++;
      tick;
    end
    check("wrap_issues", seen, 32);
    check("wrap_end", {bus.state, bus.pc, bus.issue_count}, {3'd4, 5'd0, 8'd32});

    // reset in ISSUE, loads during a run are dropped
    load_demo;
    bus.start = 1'b1;
    tick;
    bus.start     = 1'b0;
    bus.load_en   = 1'b1;
    bus.load_addr = '0;
    bus.load_data = 16'h1234;
    tick;
    bus.load_en = 1'b0;
    check("rst_mid_issue", bus.instr_valid, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rst_mid_after", {bus.state, bus.pc, bus.instr_valid, bus.instr_out}, {3'd0, 5'd0, 1'b0, 16'h0000});
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    check("rst_rerun_first", {bus.instr_valid, bus.instr_out}, {1'b1, 16'h5001});
    wait_halt("rerun", 50);

    // start and load together from HALT: the fetch sees the new word
    bus.load_en   = 1'b1;
    bus.load_addr = '0;
    bus.load_data = 16'h0777;
    bus.start     = 1'b1;
    tick;
    idle_inputs;
    tick;
    check("start_load_same_edge", {bus.instr_valid, bus.instr_out}, {1'b1, 16'h0777});
    wait_halt("start_load", 50);

    // randomized programs checked against the program-walk model
    for (int r = 0; r < 8; r++) begin
      int   h, len, idx, last, exp_pc;
      logic exp_cin, prev_valid, done, smode;
      logic [4:0] fl;
      h = $urandom_range(0, 40);
      for (int a = 0; a < DEPTH; a++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if (w == 16'hFFFF) w = 16'h0000;
        if (a == h) w = 16'hFFFF;
        prog[a] = w;
        load_word(a, w);
      end
      expq.delete();
      for (int a = 0; a < DEPTH; a++) begin
        if (prog[a] == 16'hFFFF) break;
        expq.push_back(prog[a]);
      end
      len    = expq.size();
      exp_pc = (len < DEPTH) ? len : 0;
      smode  = 1'($urandom_range(0, 1));
      bus.step_mode = smode;
      bus.start = 1'b1;
      tick;
      bus.start  = 1'b0;
      idx        = 0;
      last       = 0;
      exp_cin    = 1'b0;
      prev_valid = 1'b0;
      done       = 1'b0;
      for (int c = 1; c < 600 && !done; c++) begin
        if (bus.instr_valid) begin
          if (idx < len) begin
            check($sformatf("rnd%0d_instr%0d", r, idx), bus.instr_out, expq[idx]);
            check($sformatf("rnd%0d_cin%0d", r, idx), bus.cin_out, exp_cin);
            if (!smode) check($sformatf("rnd%0d_gap%0d", r, idx), c - last, 2);
          end else begin
            check($sformatf("rnd%0d_extra_issue", r), idx, len);
          end
          idx++;
          last = c;
        end
        if (bus.halted) begin
          done = 1'b1;
        end else begin
          fl = 5'($urandom);
          bus.flags_in = fl;
          if (prev_valid) exp_cin = fl[3];
          prev_valid    = bus.instr_valid;
          bus.step      = ($urandom_range(0, 2) == 0);
          bus.load_en   = ($urandom_range(0, 3) == 0);
          bus.load_addr = AW'($urandom);
          bus.load_data = 16'($urandom);
          tick;
        end
      end
      idle_inputs;
      check($sformatf("rnd%0d_halted", r), done, 1);
      check($sformatf("rnd%0d_issues", r), idx, len);
      check($sformatf("rnd%0d_end", r), {bus.pc, bus.issue_count}, {5'(exp_pc), 8'(len)});
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
